// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM behind a request and a response
// valid/ready handshake, with a fixed number of wait states per access.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    state_t             next_state;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [3:0]         wait_cnt;
    logic [31:0]        mem [2**ADDR_W];
    logic               accept;
    logic               access;
    logic               addr_err;
    logic [ADDR_W-1:0]  index;

    assign accept = req_valid && req_ready;
    assign access = (state == BUSY) && (wait_cnt == 4'd0);
    assign index  = addr_q[ADDR_W+1:2];

    // A sub-word offset or any address bit above the RAM rejects the access rather than aliasing.
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = BUSY;
            BUSY:    if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:    req_ready = !rst;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request fields are captured only at the accept edge; the response is cleared on its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                be_q     <= req_be;
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (access) begin
                resp_err   <= addr_err;
                resp_rdata <= (addr_err || write_q) ? 32'd0 : mem[index];
            end else if ((state == RESP) && resp_ready) begin
                resp_rdata <= '0;
                resp_err   <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; a reset before the commit edge leaves BUSY and so drops the store.
    always_ff @(posedge clk) begin
        if (access && write_q && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[index][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state and a 0-wait-state instance share stimulus,
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
    logic [31:0] resp_rdata_a, resp_rdata_b;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(req_ready_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready && !sel),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(req_ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready && sel),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    assign req_ready  = sel ? req_ready_b  : req_ready_a;
    assign resp_valid = sel ? resp_valid_b : resp_valid_a;
    assign resp_rdata = sel ? resp_rdata_b : resp_rdata_a;
    assign resp_err   = sel ? resp_err_b   : resp_err_a;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: no handshake within 100 cycles (cycle %0d)", name, cyc);
    endtask

    // Transaction-level model: a request accepted before edge E0 responds at E0 + wait + 1.
    logic [31:0] model_mem [2][1024];
    bit          known [2][1024];
    bit          txn = 1'b0;
    bit          committed = 1'b0;
    int          due = 0;
    int          txn_inst = 0;
    logic        t_write;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_be;
    logic [31:0] exp_rdata = '0;
    bit          exp_err = 1'b0;
    bit          rdata_known = 1'b0;

    always @(negedge clk) begin : monitor
        bit had_txn;
        int widx;
        if (txn && !committed && cyc >= due) begin
            committed   = 1'b1;
            exp_err     = (t_addr % 4 != 0) || (t_addr >= 32'd4096);
            exp_rdata   = '0;
            rdata_known = 1'b1;
            if (!exp_err) begin
                widx = int'(t_addr / 4);
                if (t_write) begin
                    for (int b = 0; b < 4; b++)
                        if (t_be[b]) model_mem[txn_inst][widx][8*b +: 8] = t_wdata[8*b +: 8];
                    if (t_be == 4'hF) known[txn_inst][widx] = 1'b1;
                end else begin
                    exp_rdata   = model_mem[txn_inst][widx];
                    rdata_known = known[txn_inst][widx];
                end
            end
        end
        if (rst) begin
            txn       = 1'b0;
            committed = 1'b0;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(!rst && !txn));
        checkOutput("resp_valid", 32'(resp_valid), 32'(txn && committed));
        if (txn && committed) begin
            if (rdata_known) checkOutput("resp_rdata", resp_rdata, exp_rdata);
            checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
        end else begin
            checkOutput("quiet_rdata", resp_rdata, 32'd0);
            checkOutput("quiet_err", 32'(resp_err), 32'd0);
        end
        had_txn = txn;
        if (txn && committed && resp_ready) begin
            txn       = 1'b0;
            committed = 1'b0;
        end
        if (!had_txn && !rst && req_valid) begin
            txn       = 1'b1;
            committed = 1'b0;
            txn_inst  = sel ? 1 : 0;
            due       = cyc + 2 + (sel ? 0 : 2);
            t_write   = req_write;
            t_addr    = req_addr;
            t_wdata   = req_wdata;
            t_be      = req_be;
        end
    end

    // Issues one request; either completes it (holding resp_ready low for 'hold' cycles)
    // or, when rst_after > 0, pulses reset that many edges after the accept edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input int hold, input int rst_after,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int n;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) begin
            reportTimeout("accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        if (rst_after > 0) begin
            repeat (rst_after - 1) @(posedge clk);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            if (resp_valid) break;
            lat++;
        end
        if (!resp_valid) begin
            reportTimeout("response");
            return;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            @(negedge clk);
            checkOutput("hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_rdata", resp_rdata, rdata);
            checkOutput("hold_err", 32'(resp_err), 32'(err));
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);

        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1 sel = (s == 1);
            for (int w = 0; w < 16; w++) begin
                v = 32'hA5A5A5A5 ^ (32'(w) * 32'h01010101);
                applyStimulus(1'b1, 32'(w * 4), v, 4'hF, 0, 0, rd, er, lat);
            end
        end
        @(posedge clk); #1 sel = 1'b0;

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
        checkOutput("store_latency", 32'(lat), 32'd3);
        checkOutput("store_err", 32'(er), 32'd0);
        checkOutput("store_rdata", rd, 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("load_rdata", rd, 32'hDEADBEEF);
        checkOutput("load_latency", 32'(lat), 32'd3);

        applyStimulus(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 0, rd, er, lat);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("be_merge", rd, 32'hDE22BE44);
        applyStimulus(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 0, rd, er, lat);
        checkOutput("be_zero_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 5, 0, rd, er, lat);
        checkOutput("be_zero_unchanged", rd, 32'hDE22BE44);
        @(negedge clk);
        checkOutput("ready_after_handshake", 32'(req_ready), 32'd1);

        applyStimulus(1'b0, 32'h13, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("misaligned_err", 32'(er), 32'd1);
        checkOutput("misaligned_rdata", rd, 32'd0);
        applyStimulus(1'b1, 32'h00001000, 32'h12345678, 4'hF, 0, 0, rd, er, lat);
        checkOutput("range_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("no_alias", rd, 32'hA5A5A5A5);

        applyStimulus(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 0, 0, rd, er, lat);
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 1, rd, er, lat);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("reset_drop_valid", 32'(resp_valid), 32'd0);
        end
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("reset_discard", rd, 32'h55AA55AA);
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 3, rd, er, lat);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("reset_keeps_commit", rd, 32'hCAFEF00D);

        @(posedge clk); #1 sel = 1'b1;
        applyStimulus(1'b1, 32'hFFC, 32'h13572468, 4'hF, 0, 0, rd, er, lat);
        checkOutput("w0_store_latency", 32'(lat), 32'd1);
        applyStimulus(1'b0, 32'hFFC, 32'h0, 4'h0, 0, 0, rd, er, lat);
        checkOutput("w0_load_latency", 32'(lat), 32'd1);
        checkOutput("w0_top_word", rd, 32'h13572468);

        for (int k = 0; k < 400; k++) begin
            int          pick;
            logic [31:0] a;
            @(posedge clk); #1 sel = (k >= 200);
            pick = $urandom_range(0, 9);
            if (pick < 8)       a = 32'($urandom_range(0, 15)) * 32'd4;
            else if (pick == 8) a = (32'($urandom_range(0, 15)) * 32'd4) + 32'($urandom_range(1, 3));
            else                a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
            applyStimulus(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), 0, rd, er, lat);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory interface: accepts load/store requests over a valid/ready handshake and returns a response over a second valid/ready handshake.
- Inserts a configurable number of wait states, so the pipelined and multi-cycle cores can be tested against realistic memory latency.
- Owns a word-organised RAM with byte-enable writes. Flags misaligned and out-of-range accesses instead of aliasing them.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, wait states inserted before the access completes; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; be[0] -> bits 7:0, little-endian lanes; ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester takes the response this cycle.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  access rejected: req_addr[1:0] != 0, or any of req_addr[31:ADDR_W+2] != 0.

Behaviour:
- Reset values:
  - state = IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; wait counter = 0.
  - req_ready is forced to 0 while rst is high. RAM contents are not reset.
- States:
  - IDLE: req_ready = 1, resp_valid = 0.
    - On req_valid & req_ready: latch write, addr, wdata and be into request registers; load counter = WAIT_CYCLES; go to BUSY.
  - BUSY: req_ready = 0.
    - If counter != 0: decrement counter.
    - If counter == 0: perform the access at this edge and go to RESP.
      - Error case: no RAM access; resp_err <= 1, resp_rdata <= 0.
      - Store: write each byte lane whose be bit is 1; resp_rdata <= 0.
      - Load: resp_rdata <= RAM[index].
  - RESP: resp_valid = 1, req_ready = 0.
    - resp_rdata and resp_err hold stable until resp_valid & resp_ready.
    - On that handshake, go to IDLE, clearing resp_valid, resp_rdata and resp_err.
- Latency:
  - The accept edge is E0. The store commit and resp_valid both rise at edge E0 + WAIT_CYCLES + 1.
  - Minimum request-to-request spacing is WAIT_CYCLES + 3 cycles.
  - No request is accepted in the same cycle as a response handshake.
- Loads read the full word. A store with be = 4'b0000 completes normally (err = 0) and leaves the RAM unchanged.
- req_* inputs are sampled only at the accept edge. Changes to them during BUSY/RESP have no effect.
- Reset mid-operation:
  - Returns to IDLE immediately (asynchronously) and drops resp_valid.
  - A store whose commit edge has not yet occurred is discarded.
  - A store already committed persists in the RAM.
- Counter width is 4 bits. WAIT_CYCLES = 0 gives BUSY a one-cycle residency.

Test Plan:
- Basic store/load (WAIT_CYCLES = 2):
  - After reset, store 0xDEADBEEF to 0x10 with be = 1111 -> resp_valid rises 3 cycles after the accept edge, with err = 0 and rdata = 0.
  - Load from 0x10 -> rdata = 0xDEADBEEF.
- Byte enables:
  - Store 0x11223344 to 0x10 with be = 0101 over 0xDEADBEEF -> a following load returns 0xDE22BE44.
  - Store with be = 0000 -> err = 0 and the word is unchanged.
- Backpressure:
  - Load with resp_ready held low for 5 cycles -> resp_valid, rdata and err stay stable, req_ready stays 0, and a pending req_valid is not accepted.
  - After the handshake, req_ready = 1 on the next cycle.
- Errors:
  - Load from 0x13 -> err = 1, rdata = 0.
  - Store to 0x00001000 (ADDR_W = 10) -> err = 1, and a later load of 0x0 shows the old value.
- Reset mid-operation:
  - Store 0xCAFEF00D to 0x20 is accepted; rst pulses 1 cycle later -> resp_valid stays 0, and a load of 0x20 returns the prior value.
  - Repeat with rst after the commit edge -> the load returns 0xCAFEF00D.
- Zero wait states (WAIT_CYCLES = 0 instance):
  - Store then load at top word 0xFFC -> each response arrives 1 cycle after accept, and the load returns the stored data.
